// File: rtl/seg_mux_pkg.sv
// rtl/seg_mux_pkg.sv - shared types, constants and hex decode for the seven-segment scanner
package seg_mux_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'b0;

    // Active-high segment pattern, bit order gfedcba
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] i_hex);
        logic [6:0] r_seg;
        case (i_hex)
            4'h0:    r_seg = 7'b0111111;
            4'h1:    r_seg = 7'b0000110;
            4'h2:    r_seg = 7'b1011011;
            4'h3:    r_seg = 7'b1001111;
            4'h4:    r_seg = 7'b1100110;
            4'h5:    r_seg = 7'b1101101;
            4'h6:    r_seg = 7'b1111101;
            4'h7:    r_seg = 7'b0000111;
            4'h8:    r_seg = 7'b1111111;
            4'h9:    r_seg = 7'b1101111;
            4'hA:    r_seg = 7'b1110111;
            4'hB:    r_seg = 7'b1111100;
            4'hC:    r_seg = 7'b0111001;
            4'hD:    r_seg = 7'b1011110;
            4'hE:    r_seg = 7'b1111001;
            default: r_seg = 7'b1110001;
        endcase
        return r_seg;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// rtl/seg_slot_timer.sv - per-digit slot counter, blank/drive state, digit index and frame strobe
module seg_slot_timer
    import seg_mux_pkg::*;
#(
    parameter int unsigned DIGIT_DIV    = 150000,
    parameter int unsigned BLANK_CYCLES = 2400,
    parameter int unsigned NUM_DIGITS   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    output scan_state_t                   o_state,
    output logic [$clog2(NUM_DIGITS)-1:0] o_idx,
    output logic                          o_frame
);

    localparam int CW = $clog2(DIGIT_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST    = CW'(DIGIT_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE     = CW'(DIGIT_DIV - 2);
    localparam logic [CW-1:0] CNT_BLANK_M = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    logic          r_frame;
    scan_state_t   r_state;
    scan_state_t   w_state_next;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    // r_frame is raised one cycle early so it is high during the wrap cycle itself
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_wrap ? '0 : r_cnt + CW'(1);
            r_frame <= (r_cnt == CNT_PRE) && (r_idx == IDX_LAST);
            if (w_wrap) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BLANK: if (r_cnt == CNT_BLANK_M) w_state_next = DRIVE;
            DRIVE: if (w_wrap) w_state_next = BLANK;
            default: w_state_next = BLANK;
        endcase
    end

    assign o_state = r_state;
    assign o_idx   = r_idx;
    assign o_frame = r_frame;

endmodule

// File: rtl/seg_mux_scan.sv
// rtl/seg_mux_scan.sv - N-digit multiplexed seven-segment scanner with double-buffered digits
module seg_mux_scan
    import seg_mux_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIGIT_DIV      = 150000,
    parameter int unsigned BLANK_CYCLES   = 2400,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF     = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_PIN_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    scan_state_t     w_state;
    logic [IW-1:0]   w_idx;
    logic            w_frame;

    logic [4*NUM_DIGITS-1:0] r_shd_digits;
    logic [NUM_DIGITS-1:0]   r_shd_blank;
    logic [4*NUM_DIGITS-1:0] r_act_digits;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic                    r_pending;
    logic [NUM_DIGITS-1:0]   r_digit_sel;
    logic [6:0]              r_seg;

    logic [3:0]            w_nibble;
    logic                  w_drive;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] w_sel_pin;
    logic [6:0]            w_seg_pin;

    seg_slot_timer #(
        .DIGIT_DIV    (DIGIT_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .NUM_DIGITS   (NUM_DIGITS)
    ) u_timer (
        .i_clk   (clk),
        .i_rst   (reset),
        .o_state (w_state),
        .o_idx   (w_idx),
        .o_frame (w_frame)
    );

    // A load landing on the frame boundary bypasses the shadow straight into active
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shd_digits <= '0;
            r_shd_blank  <= '0;
            r_act_digits <= '0;
            r_act_blank  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_shd_digits <= digits_in;
                r_shd_blank  <= blank_in;
            end
            if (w_frame) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_act_digits <= digits_in;
                    r_act_blank  <= blank_in;
                end else if (r_pending) begin
                    r_act_digits <= r_shd_digits;
                    r_act_blank  <= r_shd_blank;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_nibble  = r_act_digits[{w_idx, 2'b00} +: 4];
        w_drive   = (w_state == DRIVE) && !r_act_blank[w_idx];
        w_onehot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx;
        w_sel_pin = SEL_OFF;
        w_seg_pin = SEG_PIN_OFF;
        if (w_drive) begin
            w_sel_pin = SEL_ACTIVE_LOW ? ~w_onehot : w_onehot;
            w_seg_pin = SEG_ACTIVE_LOW ? ~hex_to_seg7(w_nibble) : hex_to_seg7(w_nibble);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit_sel <= SEL_OFF;
            r_seg       <= SEG_PIN_OFF;
        end else begin
            r_digit_sel <= w_sel_pin;
            r_seg       <= w_seg_pin;
        end
    end

    assign digit_sel  = r_digit_sel;
    assign seg        = r_seg;
    assign frame_tick = w_frame;
    assign pending    = r_pending;

endmodule

// File: tb/tb_seg_mux_scan.sv
// tb/tb_seg_mux_scan.sv - randomized self-checking bench for seg_mux_scan against a frame-level model
module tb_seg_mux_scan;

    localparam int N   = 2;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int P   = N * DIV;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           load = 1'b0;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]   blank_in = '0;
    logic [N-1:0]   digit_sel;
    logic [6:0]     seg;
    logic           frame_tick;
    logic           pending;

    seg_mux_scan #(
        .NUM_DIGITS     (N),
        .DIGIT_DIV      (DIV),
        .BLANK_CYCLES   (BLK),
        .SEL_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digits_in  (digits_in),
        .blank_in   (blank_in),
        .digit_sel  (digit_sel),
        .seg        (seg),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: cycle number since reset release, active/shadow digit values, pending flag
    int         c;
    logic [3:0] m_dig [N];
    logic       m_blk [N];
    logic [3:0] s_dig [N];
    logic       s_blk [N];
    logic       m_pend;
    logic [N-1:0] exp_sel;
    logic [6:0]   exp_seg;
    logic         exp_tick;
    logic         exp_pend;

    task automatic model_reset();
        c = 0;
        for (int i = 0; i < N; i++) begin
            m_dig[i] = 4'h0; m_blk[i] = 1'b0;
            s_dig[i] = 4'h0; s_blk[i] = 1'b0;
        end
        m_pend   = 1'b0;
        exp_sel  = 2'b11;
        exp_seg  = 7'h7F;
        exp_tick = 1'b0;
        exp_pend = 1'b0;
    endtask

    // Predict pins for cycle c+1 from what is shown in cycle c, then apply this cycle's load
    task automatic model_step(input logic ld, input logic [7:0] din, input logic [1:0] bin);
        int p;
        int d;
        int w;
        logic drv;
        logic [N-1:0] oh;
        p = c % P;
        d = p / DIV;
        w = p % DIV;
        drv = (w >= BLK) && !m_blk[d];
        oh = '0;
        oh[d] = 1'b1;
        exp_sel  = drv ? ~oh : 2'b11;
        exp_seg  = drv ? ~seg_tab[m_dig[d]] : 7'h7F;
        exp_tick = (((c + 1) % P) == P - 1);
        if (p == P - 1) begin
            if (ld) begin
                for (int i = 0; i < N; i++) begin
                    m_dig[i] = din[4*i +: 4]; m_blk[i] = bin[i];
                end
            end else if (m_pend) begin
                for (int i = 0; i < N; i++) begin
                    m_dig[i] = s_dig[i]; m_blk[i] = s_blk[i];
                end
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end
        if (ld) begin
            for (int i = 0; i < N; i++) begin
                s_dig[i] = din[4*i +: 4]; s_blk[i] = bin[i];
            end
        end
        exp_pend = m_pend;
        c++;
    endtask

    initial begin
        logic        ld;
        logic [7:0]  din;
        logic [1:0]  bin;
        logic        rst_done;
        rst_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_sel", 32'(digit_sel), 32'h3);
        chk("reset_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        for (int it = 0; it < 1500; it++) begin
            chk("digit_sel", 32'(digit_sel), 32'(exp_sel));
            chk("seg", 32'(seg), 32'(exp_seg));
            chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
            chk("pending", 32'(pending), 32'(exp_pend));
            if (!rst_done && it > 400 && (c % P) == 13) begin
                load  = 1'b0;
                reset = 1'b1;
                #1;
                chk("midrst_sel", 32'(digit_sel), 32'h3);
                chk("midrst_seg", 32'(seg), 32'h7F);
                chk("midrst_tick", 32'(frame_tick), 32'h0);
                chk("midrst_pend", 32'(pending), 32'h0);
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                model_reset();
                rst_done = 1'b1;
                continue;
            end
            ld  = 1'b0;
            din = 8'($urandom);
            bin = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            if (c == 3) begin
                ld = 1'b1; din = 8'hA5; bin = 2'b00;
            end else if (c == 2*P - 1) begin
                ld = 1'b1; din = 8'h3C; bin = 2'b00;
            end else if (c == 3*P + 2) begin
                ld = 1'b1; din = 8'h77; bin = 2'b10;
            end else if (c == 5*P + 1) begin
                ld = 1'b1; din = 8'h11; bin = 2'b00;
            end else if (c == 5*P + 6) begin
                ld = 1'b1; din = 8'h22; bin = 2'b00;
            end else if (c >= 7*P) begin
                ld = ($urandom_range(0, 5) == 0) ||
                     (((c % P) == P - 1) && ($urandom_range(0, 1) == 0));
            end
            load      = ld;
            digits_in = din;
            blank_in  = bin;
            model_step(ld, din, bin);
            @(negedge clk);
        end
        load = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_mux_scan.md
Name: seg_mux_scan

Overview:
- Parametrised N-digit time-multiplexed seven-segment scanner. It is the successor to the fixed two-display, clock-toggled mux scheme.
- Each digit gets a fixed scan slot, counted internally from the system clock. Each slot opens with a ghost-suppression blanking interval.
- Digit values are double-buffered, so a new value never tears mid-frame.
- Per-digit blanking and selectable pin polarities are supported.
- The block sits between the board's value sources (switches, adders, counters) and the common-segment display pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; range 2..8.
- DIGIT_DIV, 150000: clock cycles per digit slot; range 4..2^24.
- BLANK_CYCLES, 2400: cycles at the start of each slot with all digits and segments off. Must satisfy 1 <= BLANK_CYCLES < DIGIT_DIV.
- SEL_ACTIVE_LOW, 1: 1 means digit_sel pins are active-low.
- SEG_ACTIVE_LOW, 1: 1 means seg pins are active-low.

Ports:
- clk  input  1  system clock (48 MHz HSOSC)
- reset  input  1  asynchronous, active-high reset
- load  input  1  single-cycle request to capture digits_in and blank_in into the shadow registers
- digits_in  input  4*NUM_DIGITS  hex nibbles; digit i = digits_in[4i+3:4i]
- blank_in  input  NUM_DIGITS  1 = digit i stays dark during its slot
- digit_sel  output  NUM_DIGITS  one-hot digit enable, at pin polarity
- seg  output  7  segments; seg[0]=a ... seg[6]=g, at pin polarity
- frame_tick  output  1  one-cycle pulse at the end of the last digit's slot
- pending  output  1  1 = shadow holds data not yet promoted to active

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - slot counter = 0, digit index = 0, state = BLANK.
  - shadow and active registers = 0 (all digits 0, unblanked); pending = 0; frame_tick = 0.
  - digit_sel and seg are driven to their inactive pin levels: all 1 if the matching ACTIVE_LOW = 1, else all 0.
- Slot counter:
  - Counts 0..DIGIT_DIV-1 and wraps to 0.
  - At wrap, the digit index increments modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
- State machine, per slot:
  - BLANK while counter < BLANK_CYCLES; DRIVE for the remaining cycles.
  - BLANK -> DRIVE when counter reaches BLANK_CYCLES.
  - DRIVE -> BLANK at counter wrap.
- Frame boundary = the cycle in which the counter wraps while index = NUM_DIGITS-1.
  - frame_tick is asserted for exactly that cycle.
  - If pending = 1, shadow is copied to active in that cycle and pending clears.
- load handling:
  - load=1 writes digits_in and blank_in into shadow and sets pending.
  - load coinciding with a frame boundary: the new data is written to both shadow and active; pending ends at 0.
  - A later load before the next frame boundary overwrites shadow (last write wins).
- Outputs:
  - All outputs are registered.
  - Pins reflect state and index with exactly 1 clock of latency.
  - In DRIVE: digit_sel asserts only bit [index]; seg = decode(active nibble[index]).
  - If blank of the indexed digit is 1: digit_sel and seg are inactive for the whole slot; slot timing is unchanged.
  - In BLANK: all digit_sel and seg bits are inactive.
  - digit_sel never has more than one active bit in any cycle, including across index changes.
- Decode (active-high before polarity inversion), listed as gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Reset mid-slot: all outputs go inactive asynchronously. After reset deasserts, the scan restarts at digit 0, BLANK, counter 0.

Decomposition:
- Package seg_mux_pkg holds:
  - typedef scan_state_t {BLANK, DRIVE}.
  - constant SEG_OFF = 7'b0.
  - function hex_to_seg7(logic [3:0]) -> logic [6:0].
- One sub-module: seg_slot_timer.
  - Contents: slot counter, state, digit index, frame-boundary strobe.
  - Parameters: DIGIT_DIV, BLANK_CYCLES, NUM_DIGITS.
  - seg_mux_scan itself holds the buffers, decode and output registers.

Test Plan (NUM_DIGITS=2, DIGIT_DIV=8, BLANK_CYCLES=2, both ACTIVE_LOW=1):
- Reset release -> digit_sel=2'b11 and seg=7'h7F for cycles 0..2. In cycles 3..8, digit_sel=2'b10 and seg=~7'h3F (value 0). frame_tick pulses once every 16 cycles.
- load with digits_in=8'hA5 mid digit-0 slot -> pending=1. Display is unchanged until frame_tick. Next frame shows digit0 seg=~7'h6D ("5") and digit1 seg=~7'h77 ("A"); pending=0.
- load of 8'h3C in the same cycle as frame_tick -> pending stays 0. The next slot shows "C" on digit 0 immediately after its blank interval.
- blank_in=2'b10 loaded -> digit 1 slot has digit_sel=2'b11 and seg=7'h7F for all 8 cycles. Digit 0 is unaffected and frame period stays 16 cycles.
- Two loads (8'h11 then 8'h22) within one frame -> only 8'h22 is ever displayed.
- reset asserted at counter=5 of digit 1 -> outputs inactive in the same cycle. After release, digit 0 is displayed first with values 0, following the full blank interval.
